// File: rtl/soric_core_sched.sv
// SoRIC ibex cluster sequencer and shared-SRAM arbiter.
// Walks the cores through IDLE -> PROG -> BOOT -> RUN -> DONE from the pad control word.
// In PROG the Wishbone host owns the SRAM; in RUN the enabled cores share it round-robin.
// Optional watchdog in RUN: define SORIC_WDT_EN.
module soric_core_sched #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned AW          = 10,
  parameter int unsigned BOOT_CYCLES = 8,
  parameter int unsigned WDT_CYCLES  = 65536
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [9:0]              ctrl_i,
  input  logic                    host_req_i,
  input  logic                    host_we_i,
  input  logic [AW-1:0]           host_addr_i,
  input  logic [31:0]             host_wdata_i,
  output logic                    host_gnt_o,
  output logic                    host_rvalid_o,
  input  logic [NUM_CORES-1:0]    core_req_i,
  input  logic [NUM_CORES-1:0]    core_we_i,
  input  logic [NUM_CORES*AW-1:0] core_addr_i,
  input  logic [NUM_CORES*32-1:0] core_wdata_i,
  output logic [NUM_CORES-1:0]    core_gnt_o,
  output logic [NUM_CORES-1:0]    core_rvalid_o,
  output logic [31:0]             rdata_o,
  input  logic [NUM_CORES-1:0]    core_halt_i,
  output logic [NUM_CORES-1:0]    core_rst_no,
  output logic [NUM_CORES-1:0]    core_fetch_en_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [AW-1:0]           mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic [31:0]             mem_rdata_i,
  output logic [2:0]              state_o,
  output logic                    err_o,
  output logic                    done_o
);

  localparam int unsigned PtrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CntW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StProg = 3'd1,
    StBoot = 3'd2,
    StRun  = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [9:0]           ctrl_meta_q, ctrl_s_q;
  logic                 start_prev_q;
  logic [NUM_CORES-1:0] mask_q, mask_d, mask_in;
  logic [CntW-1:0]      boot_cnt_q, boot_cnt_d;
  logic [PtrW-1:0]      rr_q, rr_d;
  logic                 host_rvalid_q, host_rvalid_d;
  logic [NUM_CORES-1:0] core_rvalid_q, core_rvalid_d;
  logic                 err_q, err_d;

  logic                 prog, start_rise, all_halted, abort, zero_start, wdt_trip;
  logic [NUM_CORES-1:0] req_m, gnt_vec;
  logic [PtrW-1:0]      gnt_idx;
  logic                 gnt_found;

  assign prog       = ctrl_s_q[4];
  assign start_rise = ctrl_s_q[5] & ~start_prev_q;
  assign all_halted = ((core_halt_i & mask_q) == mask_q);
  assign abort      = (state_q == StRun) && !prog;
  assign zero_start = (state_q == StProg) && prog && start_rise && (mask_in == '0);

  // Reserved control bits are synchronized but deliberately unused.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_s_q[9:6];

  // Two-flop synchronizer for the asynchronous pad word, plus start edge history.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_meta_q  <= '0;
      ctrl_s_q     <= '0;
      start_prev_q <= 1'b0;
    end else begin
      ctrl_meta_q  <= ctrl_i;
      ctrl_s_q     <= ctrl_meta_q;
      start_prev_q <= ctrl_s_q[5];
    end
  end

  // Enable mask from the pad word, keeping only bits that name a real core.
  always_comb begin
    mask_in = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (i < 4) mask_in[i] = ctrl_s_q[i];
    end
  end

`ifdef SORIC_WDT_EN
  logic [31:0] wdt_q, wdt_d;

  // Watchdog counts RUN cycles; it restarts from zero on every RUN entry.
  always_comb begin
    wdt_d = (state_q == StRun) ? wdt_q + 32'd1 : 32'd0;
  end

  // Watchdog register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wdt_q <= '0;
    else          wdt_q <= wdt_d;
  end

  assign wdt_trip = (state_q == StRun) && prog && !all_halted &&
                    (wdt_q == 32'(WDT_CYCLES - 1));
`else
  logic [31:0] unused_wdt;
  assign unused_wdt = 32'(WDT_CYCLES);
  assign wdt_trip   = 1'b0;
`endif

  // Round-robin search over masked requests, starting at the pointer.
  always_comb begin
    int cand;
    logic [PtrW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    req_m     = (state_q == StRun) ? (core_req_i & mask_q) : '0;
    for (int off = 0; off < NUM_CORES; off++) begin
      cand = int'(rr_q) + off;
      if (cand >= int'(NUM_CORES)) cand = cand - int'(NUM_CORES);
      cand_idx = PtrW'(cand);
      if (!gnt_found && req_m[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    if (gnt_found) gnt_vec[gnt_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic; abort has priority over halt and watchdog in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (prog) state_d = StProg;
      StProg: begin
        if (!prog)                                state_d = StIdle;
        else if (start_rise && (mask_in != '0))  state_d = StBoot;
      end
      StBoot: if (boot_cnt_q == CntW'(BOOT_CYCLES - 1)) state_d = StRun;
      StRun: begin
        if (!prog)          state_d = StIdle;
        else if (all_halted) state_d = StDone;
        else if (wdt_trip)   state_d = StDone;
      end
      StDone: if (!prog && !ctrl_s_q[5]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: mask latch, boot counter, rr pointer, read responses, sticky error.
  always_comb begin
    mask_d = mask_q;
    if ((state_q == StProg) && prog && start_rise) mask_d = mask_in;
    boot_cnt_d = (state_q == StBoot) ? boot_cnt_q + 1'b1 : '0;
    rr_d = rr_q;
    if (gnt_found) rr_d = (gnt_idx == PtrW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
    host_rvalid_d = (state_q == StProg) && host_req_i && !host_we_i;
    // A read granted in the abort cycle must not answer after the cores are reset.
    core_rvalid_d = abort ? '0 : (gnt_vec & ~core_we_i);
    err_d         = err_q | zero_start | wdt_trip;
  end

  // Datapath registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mask_q        <= '0;
      boot_cnt_q    <= '0;
      rr_q          <= '0;
      host_rvalid_q <= 1'b0;
      core_rvalid_q <= '0;
      err_q         <= 1'b0;
    end else begin
      mask_q        <= mask_d;
      boot_cnt_q    <= boot_cnt_d;
      rr_q          <= rr_d;
      host_rvalid_q <= host_rvalid_d;
      core_rvalid_q <= core_rvalid_d;
      err_q         <= err_d;
    end
  end

  // State-decoded outputs and SRAM port steering.
  always_comb begin
    host_gnt_o      = 1'b0;
    core_gnt_o      = '0;
    core_rst_no     = '0;
    core_fetch_en_o = '0;
    done_o          = 1'b0;
    mem_en_o        = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    case (state_q)
      StProg: begin
        host_gnt_o  = host_req_i;
        mem_en_o    = host_req_i;
        mem_we_o    = host_we_i;
        mem_addr_o  = host_addr_i;
        mem_wdata_o = host_wdata_i;
      end
      StBoot: core_rst_no = mask_q;
      StRun: begin
        core_rst_no     = mask_q;
        core_fetch_en_o = mask_q;
        core_gnt_o      = gnt_vec;
        if (gnt_found) begin
          mem_en_o    = 1'b1;
          mem_we_o    = core_we_i[gnt_idx];
          mem_addr_o  = core_addr_i[gnt_idx*AW +: AW];
          mem_wdata_o = core_wdata_i[gnt_idx*32 +: 32];
        end
      end
      StDone: begin
        core_rst_no = mask_q;
        done_o      = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign err_o         = err_q;
  assign host_rvalid_o = host_rvalid_q;
  assign core_rvalid_o = core_rvalid_q;
  assign rdata_o       = mem_rdata_i;

endmodule

// File: tb/tb_soric_core_sched.sv
// Self-checking bench for soric_core_sched: scenario tasks with a read-response scoreboard.
module tb_soric_core_sched;
  localparam int NC = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    ctrl;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic          host_gnt, host_rvalid;
  logic [NC-1:0] core_req, core_we, core_gnt, core_rvalid, core_halt, core_rst_n, core_fetch;
  logic [NC*AW-1:0] core_addr;
  logic [NC*32-1:0] core_wdata;
  logic [31:0]   rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [2:0]    state;
  logic          err, done;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [NC-1:0] rv;
    logic [31:0]   data;
  } exp_t;
  exp_t        core_sb[$];
  logic [31:0] host_sb[$];

  always #5 clk = ~clk;

  soric_core_sched #(
    .NUM_CORES(NC), .AW(AW), .BOOT_CYCLES(8), .WDT_CYCLES(100)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ctrl_i(ctrl),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .rdata_o(rdata), .core_halt_i(core_halt), .core_rst_no(core_rst_n),
    .core_fetch_en_o(core_fetch), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .state_o(state), .err_o(err), .done_o(done)
  );

  // Behavioural SRAM: one-cycle read latency.
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = (state === s);
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (state === s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (state !== 3'd0) $display("FAIL reset_state got %0d exp 0", state); else passed++;
    total++; if (core_rst_n !== 4'b0) $display("FAIL reset_rstn got %b exp 0000", core_rst_n); else passed++;
    total++; if ({host_gnt, core_gnt, core_fetch, mem_en, err, done} !== '0)
      $display("FAIL reset_outs got %b exp 0", {host_gnt, core_gnt, core_fetch, mem_en, err, done});
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_prog();
    bit ok;
    logic [31:0] e;
    ctrl = 10'h010;
    wait_state(3'd1, 6, ok);
    total++; if (!ok) $display("FAIL prog_enter got %0d exp 1", state); else passed++;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'd5; host_wdata = 32'hDEADBEEF;
    #1;
    total++; if ({host_gnt, mem_en, mem_we, mem_addr} !== {3'b111, 10'd5})
      $display("FAIL prog_wr5 got %b exp 111_0000000101", {host_gnt, mem_en, mem_we, mem_addr});
    else passed++;
    step();
    host_addr = 10'd6; host_wdata = 32'h12345678;
    #1;
    total++; if (host_gnt !== 1'b1) $display("FAIL prog_wr6_gnt got %b exp 1", host_gnt); else passed++;
    step();
    host_we = 1'b0; host_addr = 10'd5;
    #1;
    total++; if (host_gnt !== 1'b1) $display("FAIL prog_rd_gnt got %b exp 1", host_gnt); else passed++;
    host_sb.push_back(32'hDEADBEEF);
    step();
    host_req = 1'b0;
    #1;
    e = host_sb.pop_front();
    total++; if (host_rvalid !== 1'b1 || rdata !== e)
      $display("FAIL prog_rd_data got rv=%b %h exp rv=1 %h", host_rvalid, rdata, e);
    else passed++;
    step();
    total++; if (host_rvalid !== 1'b0) $display("FAIL prog_rv_once got %b exp 0", host_rvalid); else passed++;
  endtask

  task automatic test_boot();
    bit ok;
    int n;
    ctrl = 10'h036;
    wait_state(3'd2, 6, ok);
    total++; if (!ok) $display("FAIL boot_enter got %0d exp 2", state); else passed++;
    total++; if (core_rst_n !== 4'b0110 || core_fetch !== 4'b0000)
      $display("FAIL boot_outs got rstn=%b fe=%b exp 0110 0000", core_rst_n, core_fetch);
    else passed++;
    n = 1;
    step();
    while (state === 3'd2 && n < 50) begin
      n++;
      step();
    end
    total++; if (n !== 8) $display("FAIL boot_len got %0d exp 8", n); else passed++;
    total++; if (state !== 3'd3 || core_fetch !== 4'b0110)
      $display("FAIL run_enter got st=%0d fe=%b exp 3 0110", state, core_fetch);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] exp_g [6];
    exp_t e;
    exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010, 4'b0100};
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'd5;
    core_we = '0;
    core_addr = {10'd0, 10'd6, 10'd5, 10'd7};
    core_req = 4'b0111;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (core_sb.size() > 0) begin
        e = core_sb.pop_front();
        total++; if (core_rvalid !== e.rv || rdata !== e.data)
          $display("FAIL rr_resp%0d got rv=%b %h exp rv=%b %h", i, core_rvalid, rdata, e.rv, e.data);
        else passed++;
      end
      total++; if (core_gnt !== exp_g[i])
        $display("FAIL rr_gnt%0d got %b exp %b", i, core_gnt, exp_g[i]);
      else passed++;
      total++; if (host_gnt !== 1'b0) $display("FAIL rr_host_gnt%0d got %b exp 0", i, host_gnt); else passed++;
      core_sb.push_back('{rv: exp_g[i], data: (exp_g[i] == 4'b0010) ? 32'hDEADBEEF : 32'h12345678});
      step();
    end
    core_req = '0; host_req = 1'b0;
    #1;
    e = core_sb.pop_front();
    total++; if (core_rvalid !== e.rv || rdata !== e.data)
      $display("FAIL rr_resp_last got rv=%b %h exp rv=%b %h", core_rvalid, rdata, e.rv, e.data);
    else passed++;
    step();
    total++; if (core_rvalid !== 4'b0) $display("FAIL rr_idle_rv got %b exp 0000", core_rvalid); else passed++;
  endtask

  task automatic test_done();
    bit ok;
    core_halt = 4'b0010;
    step(); step();
    total++; if (state !== 3'd3) $display("FAIL partial_halt got %0d exp 3", state); else passed++;
    core_halt = 4'b0110;
    step();
    total++; if (state !== 3'd4 || done !== 1'b1 || core_fetch !== 4'b0 || core_rst_n !== 4'b0110)
      $display("FAIL done_outs got st=%0d d=%b fe=%b rstn=%b exp 4 1 0000 0110",
               state, done, core_fetch, core_rst_n);
    else passed++;
    ctrl = 10'h000;
    wait_state(3'd0, 6, ok);
    total++; if (!ok || core_rst_n !== 4'b0 || done !== 1'b0)
      $display("FAIL done_exit got st=%0d rstn=%b d=%b exp 0 0000 0", state, core_rst_n, done);
    else passed++;
    core_halt = '0;
  endtask

  task automatic test_err_abort();
    bit ok;
    int n;
    ctrl = 10'h010;
    wait_state(3'd1, 6, ok);
    total++; if (!ok || err !== 1'b0) $display("FAIL err_pre got st=%0d err=%b exp 1 0", state, err); else passed++;
    ctrl = 10'h030;
    repeat (6) step();
    total++; if (state !== 3'd1 || err !== 1'b1)
      $display("FAIL zero_mask got st=%0d err=%b exp 1 1", state, err);
    else passed++;
    ctrl = 10'h010;
    repeat (4) step();
    ctrl = 10'h3F2;  // reserved bits set, mask = core 1 only
    wait_state(3'd3, 20, ok);
    total++; if (!ok || core_fetch !== 4'b0010)
      $display("FAIL abort_run got st=%0d fe=%b exp 3 0010", state, core_fetch);
    else passed++;
    core_we = '0; core_addr = {10'd0, 10'd0, 10'd5, 10'd0}; core_req = 4'b0010;
    ctrl = 10'h000;
    n = 0;
    while (state !== 3'd0 && n < 10) begin
      step();
      n++;
    end
    total++; if (state !== 3'd0 || n > 3) $display("FAIL abort_lat got %0d cycles exp <=3", n); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (core_rvalid !== 4'b0 || core_gnt !== 4'b0 || core_rst_n !== 4'b0)
        $display("FAIL abort_quiet%0d got rv=%b g=%b rstn=%b exp 0", i, core_rvalid, core_gnt, core_rst_n);
      else passed++;
      step();
    end
    core_req = '0;
    total++; if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err); else passed++;
  endtask

`ifdef SORIC_WDT_EN
  task automatic test_wdt();
    bit ok;
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    total++; if (err !== 1'b0) $display("FAIL wdt_rst_err got %b exp 0", err); else passed++;
    ctrl = 10'h010;
    repeat (5) step();
    ctrl = 10'h032;
    wait_state(3'd3, 25, ok);
    total++; if (!ok) $display("FAIL wdt_run got %0d exp 3", state); else passed++;
    n = 1;
    step();
    while (state === 3'd3 && n < 300) begin
      n++;
      step();
    end
    total++; if (n !== 100 || state !== 3'd4 || err !== 1'b1)
      $display("FAIL wdt_trip got n=%0d st=%0d err=%b exp 100 4 1", n, state, err);
    else passed++;
    ctrl = 10'h000;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ctrl = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0; core_halt = '0;
    test_reset();
    test_prog();
    test_boot();
    test_round_robin();
    test_done();
    test_err_abort();
`ifdef SORIC_WDT_EN
    test_wdt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
